lfsr_rng: RTL
=============

LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 SHALL have parameter WIDTH, default 16: LFSR state width; legal range 3..64.
REQ-002 SHALL have parameter TAPS, default 16'hD008: feedback tap mask; bit i set means state bit i feeds back; bit WIDTH-1 SHALL be set.
REQ-003 SHALL have parameter SEED, default 5: reset and recovery value; SHALL not be all-ones.
REQ-004 SHALL have parameter SUB_WIDTH, default 4: width of the low-bit sub-output; legal range 1..WIDTH.
REQ-005 SHALL have parameter STEP_W, default 4: width of the steps port.
REQ-006 SHALL have port clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-008 SHALL have port en_rng, input, 1 bit: start request.
REQ-009 SHALL have port steps, input, STEP_W bits: number of shifts per request.
REQ-010 SHALL have port load, input, 1 bit: seed-load strobe.
REQ-011 SHALL have port load_val, input, WIDTH bits: value written on load.
REQ-012 SHALL have port rng_out, output, WIDTH bits: current LFSR state.
REQ-013 SHALL have port rng_out_sub, output, WIDTH bits: {zeros, state[SUB_WIDTH-1:0]}.
REQ-014 SHALL have port busy, output, 1 bit: high in STEP and DONE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port lockup, output, 1 bit: one-cycle pulse on all-ones recovery.

Function
REQ-017 SHALL implement states IDLE, STEP and DONE.
REQ-018 SHALL compute one step as: feedback = XNOR of all state bits selected by TAPS; next = {state[WIDTH-2:0], feedback}.
REQ-019 SHALL, in IDLE with en_rng=1 and load=0, latch count = steps (0 treated as 1) and enter STEP.
REQ-020 SHALL, in STEP, perform one shift per cycle; on the final shift, enter DONE and set done=1 on that same edge.
REQ-021 SHALL, in DONE, hold rng_out stable, clear done at the next edge and return to IDLE; done is high for exactly one cycle.
REQ-022 SHALL give done high, with start sampled at edge k, from edge k+count until edge k+count+1.
REQ-023 SHALL, in IDLE with load=1, set state=load_val at the next edge; load has priority and en_rng in that cycle is dropped.
REQ-024 SHALL ignore load and en_rng in STEP and DONE; they SHALL not be queued.
REQ-025 SHALL hold rng_out unchanged in IDLE when no load occurs.

Reset
REQ-026 SHALL, when rst=1 at an edge (including mid-STEP), set state=SEED and FSM=IDLE, clear count, and set done=0, lockup=0 and busy=0.

Configuration
REQ-027 SHALL, with macro LFSR_RNG_LOCKUP_RECOVERY_EN defined, replace an all-ones value produced by a shift or a load with SEED on the same edge and pulse lockup for one cycle.
REQ-028 SHALL, without LFSR_RNG_LOCKUP_RECOVERY_EN, accept the all-ones state unchanged (it persists) and tie lockup to 0.

Structure
REQ-029 SHALL define in package lfsr_rng_pkg: the FSM state enum and default tap constants for widths 8 (8'hB8), 16 (16'hD008) and 32 (32'h80200003).
REQ-030 SHALL place the one-step feedback/shift in combinational sub-module lfsr_rng_step (parameters WIDTH, TAPS).

Verification
REQ-031 SHALL cover: defaults, reset, en_rng=1, steps=1 -> rng_out=16'h000B, done one cycle at edge k+1.
REQ-032 SHALL cover: from reset, steps=2 -> rng_out=16'h0016 at done; busy high for 3 cycles.
REQ-033 SHALL cover: steps=0 -> behaves as steps=1 (16'h000B).
REQ-034 SHALL cover: load=1, load_val=16'h1234, en_rng=1 in the same cycle -> rng_out=16'h1234, no busy, no done.
REQ-035 SHALL cover: load_val=16'hFFFF -> with macro rng_out=16'h0005 and lockup pulse; without macro rng_out=16'hFFFF and still 16'hFFFF after steps=3.
REQ-036 SHALL cover: rst asserted mid-STEP (steps=8) -> next cycle rng_out=16'h0005, busy=0, done never pulses.

Source files
------------

// File: rtl/lfsr_rng_pkg.sv
// Shared types and default tap masks for the XNOR-feedback LFSR random generator.
// Each default mask is maximal-length for its width.
package lfsr_rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } rng_state_e;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hD008;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

endpackage

// File: rtl/lfsr_rng_step.sv
// Single combinational LFSR shift: XNOR of the tapped bits enters at bit 0.
// Zero latency; pure logic, no flow control.
module lfsr_rng_step #(
  parameter int                 WIDTH = 16,
  parameter logic [WIDTH-1:0]   TAPS  = 16'hD008
) (
  input  logic [WIDTH-1:0] cur_val,
  output logic [WIDTH-1:0] nxt_val
);

  logic feedback;

  // XNOR form makes all-ones the lock-up state, so all-zeros is a legal seed.
  assign feedback = ~^(cur_val & TAPS);
  assign nxt_val  = {cur_val[WIDTH-2:0], feedback};

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random generator: each start request performs 'steps' shifts (0 counts as 1), then pulses done.
// Latency: done at edge k+count; start/load ignored while busy. Optional LFSR_RNG_LOCKUP_RECOVERY_EN reseeds on all-ones.
module lfsr_rng
  import lfsr_rng_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED      = 5,
  parameter int               SUB_WIDTH = 4,
  parameter int               STEP_W    = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en_rng,
  input  logic [STEP_W-1:0] steps,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  rng_out,
  output logic [WIDTH-1:0]  rng_out_sub,
  output logic              busy,
  output logic              done,
  output logic              lockup
);

  localparam logic [WIDTH-1:0] SUB_MASK = {WIDTH{1'b1}} >> (WIDTH - SUB_WIDTH);

  rng_state_e        fsm_q, fsm_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  step_val;
  logic [WIDTH-1:0]  upd_val;
  logic              upd;
  logic [STEP_W-1:0] count_q, count_d;
  logic              done_d;
  logic              lockup_d;

  lfsr_rng_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .cur_val (lfsr_q),
    .nxt_val (step_val)
  );

  always_comb begin
    fsm_d    = fsm_q;
    lfsr_d   = lfsr_q;
    count_d  = count_q;
    done_d   = 1'b0;
    lockup_d = 1'b0;
    upd      = 1'b0;
    upd_val  = lfsr_q;

    case (fsm_q)
      IDLE: begin
        if (load) begin
          upd     = 1'b1;
          upd_val = load_val;
        end else if (en_rng) begin
          fsm_d   = STEP;
          count_d = (steps == '0) ? STEP_W'(1) : steps;
        end
      end
      STEP: begin
        upd     = 1'b1;
        upd_val = step_val;
        count_d = count_q - 1'b1;
        if (count_q <= STEP_W'(1)) begin
          fsm_d  = DONE;
          done_d = 1'b1;
        end
      end
      DONE: fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase

    if (upd) begin
      lfsr_d = upd_val;
`ifdef LFSR_RNG_LOCKUP_RECOVERY_EN
      // All-ones is the XNOR LFSR's stuck state; substitute the seed on the same edge.
      if (&upd_val) begin
        lfsr_d   = SEED;
        lockup_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      fsm_q   <= IDLE;
      lfsr_q  <= SEED;
      count_q <= '0;
      done    <= 1'b0;
      lockup  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      done    <= done_d;
      lockup  <= lockup_d;
    end
  end

  assign rng_out     = lfsr_q;
  assign rng_out_sub = lfsr_q & SUB_MASK;
  assign busy        = (fsm_q != IDLE);

endmodule
